// File: rtl/ysyx_22050550_wb_arbiter.sv
// Writeback arbiter and register scoreboard: EXU and LSU share one register-file
// write port through an output register, while decode sees pending-write hazards.
`timescale 1ns/1ps
module ysyx_22050550_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int REG_NUM    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_wen,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                hazard1,
  output logic                hazard2,
  input  logic                exu_valid,
  input  logic [ADDR_W-1:0]   exu_rd,
  input  logic [DATA_W-1:0]   exu_data,
  output logic                exu_ready,
  input  logic                lsu_valid,
  input  logic [ADDR_W-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  output logic                lsu_ready,
  output logic                rf_wen,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [REG_NUM-1:0]  busy,
  output logic                wb_err
);

  // Handshake: a writeback transfers on the cycle where valid & ready are both
  // high; the requester holds rd/data stable until then.
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]   starve_cnt;
  logic               starved;
  logic               grant_exu;
  logic               grant_lsu;
  logic [ADDR_W-1:0]  win_rd;
  logic [DATA_W-1:0]  win_data;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] busy_next;

  assign starved   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_exu = rst_n & exu_valid & (!lsu_valid | starved);
  assign grant_lsu = rst_n & lsu_valid & !grant_exu;
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign win_rd    = grant_exu ? exu_rd : lsu_rd;
  assign win_data  = grant_exu ? exu_data : lsu_data;

  // The register being committed this cycle is forwarded by the register file,
  // so it is neither a hazard nor a WAW conflict.
  assign issue_ready = rst_n & !(issue_wen & (issue_rd != '0) & busy[issue_rd]
                                 & !(rf_wen & (rf_rd == issue_rd)));
  assign hazard1 = (rs1 != '0) & busy[rs1] & !(rf_wen & (rf_rd == rs1));
  assign hazard2 = (rs2 != '0) & busy[rs2] & !(rf_wen & (rf_rd == rs2));

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid & issue_ready & issue_wen & (issue_rd != '0))
      set_mask[issue_rd] = 1'b1;
    if (rf_wen)
      clr_mask[rf_rd] = 1'b1;
    // Set after clear so a same-edge reissue of the committing register wins.
    busy_next = ((busy & ~clr_mask) | set_mask) & ~REG_NUM'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      busy       <= '0;
      wb_err     <= 1'b0;
    end else begin
      if (!exu_valid || exu_ready)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (grant_exu || grant_lsu) begin
        rf_wen   <= (win_rd != '0);
        rf_rd    <= win_rd;
        rf_wdata <= win_data;
      end else begin
        rf_wen   <= 1'b0;
      end

      busy <= busy_next;
      if (rf_wen && !busy[rf_rd])
        wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_wb_arbiter.sv
// Directed bench for the writeback arbiter: a per-cycle monitor checks grants and
// the registered write port against an expected queue filled from the stimulus.
`timescale 1ns/1ps
module tb_ysyx_22050550_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wen, issue_ready;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        hazard1, hazard2;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [63:0] exu_data, lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic [31:0] busy;
  logic        wb_err;

  logic        exp_e = 1'b0;
  logic        exp_l = 1'b0;
  logic [69:0] exp_q[$];
  logic [69:0] mon_e;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ysyx_22050550_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .rs1(rs1), .rs2(rs2),
    .hazard1(hazard1), .hazard2(hazard2),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd);
    issue_valid = v;
    issue_wen   = v;
    issue_rd    = rd;
  endtask

  task automatic set_exu(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic g);
    exu_valid = v;
    exu_rd    = rd;
    exu_data  = d;
    exp_e     = g;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic g);
    lsu_valid = v;
    lsu_rd    = rd;
    lsu_data  = d;
    exp_l     = g;
  endtask

  // Each negedge: compare last cycle's expected write, check grants, queue this cycle's write.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rf_wen", rf_wen, mon_e[69]);
      if (mon_e[69]) begin
        check("rf_rd", rf_rd, mon_e[68:64]);
        check("rf_wdata", rf_wdata, mon_e[63:0]);
      end
    end
    check("exu_ready", exu_ready, exp_e);
    check("lsu_ready", lsu_ready, exp_l);
    if (exp_e)      exp_q.push_back({exu_rd != 5'd0, exu_rd, exu_data});
    else if (exp_l) exp_q.push_back({lsu_rd != 5'd0, lsu_rd, lsu_data});
    else            exp_q.push_back(70'd0);
  end

  logic [4:0] iss_rds [6];
  logic [4:0] lsu_rds [4];

  initial begin
    iss_rds = '{5'd1, 5'd2, 5'd10, 5'd11, 5'd12, 5'd13};
    lsu_rds = '{5'd2, 5'd10, 5'd11, 5'd12};
    rst_n = 1'b0;
    rs1 = '0;
    rs2 = '0;
    set_issue(1'b1, 5'd8);
    set_exu(1'b1, 5'd4, 64'h11, 1'b0);
    set_lsu(1'b1, 5'd6, 64'h22, 1'b0);

    // Reset with both requesters active, then release: LSU first, EXU next.
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_issue_ready", issue_ready, 0);
    tick(); rst_n = 1'b1; set_issue(1'b0, 5'd0); exp_l = 1'b1;
    tick(); set_lsu(1'b0, 5'd0, 64'd0, 1'b0); exp_e = 1'b1;
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
    check("rel_wb_err", wb_err, 1);
    tick(); rst_n = 1'b0;
    tick();
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("rst2_wb_err", wb_err, 0);
    check("rst2_busy", busy, 0);

    // Simple EXU writeback to rd 5.
    tick(); set_issue(1'b1, 5'd5);
    @(negedge clk); check("wb5_issue_ready", issue_ready, 1);
    tick(); set_issue(1'b0, 5'd0); set_exu(1'b1, 5'd5, 64'hDEAD, 1'b1); rs1 = 5'd5;
    @(negedge clk); check("wb5_busy_set", busy[5], 1); check("wb5_hazard1_pend", hazard1, 1);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("wb5_rf_wen", rf_wen, 1); check("wb5_hazard1_bypass", hazard1, 0);
    tick();
    @(negedge clk); check("wb5_busy_clr", busy[5], 0); check("wb5_hazard1_after", hazard1, 0);
    rs1 = 5'd0;

    // RAW hazard on rs2 = 7.
    tick(); set_issue(1'b1, 5'd7); rs2 = 5'd7;
    @(negedge clk); check("hz_issue_cycle", hazard2, 0);
    tick(); set_issue(1'b0, 5'd0);
    @(negedge clk); check("hz_pending_a", hazard2, 1); check("hz_rs1_x0", hazard1, 0);
    tick();
    @(negedge clk); check("hz_pending_b", hazard2, 1);
    tick(); set_lsu(1'b1, 5'd7, 64'h77, 1'b1);
    @(negedge clk); check("hz_grant_cycle", hazard2, 1);
    tick(); set_lsu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("hz_commit_cycle", hazard2, 0);
    tick();
    @(negedge clk); check("hz_cleared", hazard2, 0); check("hz_busy7", busy[7], 0);
    rs2 = 5'd0;

    // Starvation: LSU keeps winning until EXU has waited STARVE_MAX cycles.
    for (int i = 0; i < 6; i++) begin
      tick(); set_issue(1'b1, iss_rds[i]);
      @(negedge clk); check("sv_issue_ready", issue_ready, 1);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); set_issue(1'b0, 5'd0);
      set_exu(1'b1, 5'd1, 64'h1111, 1'b0);
      set_lsu(1'b1, lsu_rds[k], 64'h2000 + 64'(k), 1'b1);
    end
    tick(); set_exu(1'b1, 5'd1, 64'h1111, 1'b1); set_lsu(1'b1, 5'd13, 64'h3013, 1'b0);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0); set_lsu(1'b1, 5'd13, 64'h3013, 1'b1);
    tick(); set_exu(1'b1, 5'd0, 64'h55, 1'b0); set_lsu(1'b1, 5'd0, 64'h66, 1'b1);
    tick(); set_exu(1'b1, 5'd0, 64'h55, 1'b1); set_lsu(1'b0, 5'd0, 64'd0, 1'b0);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("sv_x0_rf_wen", rf_wen, 0); check("sv_busy", busy, 0);
    check("sv_wb_err", wb_err, 0);

    // WAW stall on rd 3, then reissue on the commit edge.
    tick(); set_issue(1'b1, 5'd3);
    @(negedge clk); check("waw_first", issue_ready, 1);
    tick();
    @(negedge clk); check("waw_stall_a", issue_ready, 0);
    tick(); set_exu(1'b1, 5'd3, 64'h33, 1'b1);
    @(negedge clk); check("waw_stall_b", issue_ready, 0);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("waw_commit_ready", issue_ready, 1);
    tick(); set_issue(1'b0, 5'd0);
    @(negedge clk); check("waw_set_wins", busy[3], 1); check("waw_wb_err", wb_err, 0);
    tick(); set_exu(1'b1, 5'd3, 64'h34, 1'b1);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    @(negedge clk); check("waw_busy_clr", busy, 0); check("waw_wb_err2", wb_err, 0);

    // Writeback to a non-busy register, then an x0 writeback.
    tick(); set_lsu(1'b1, 5'd9, 64'h99, 1'b1);
    tick(); set_lsu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("err_before", wb_err, 0);
    tick();
    @(negedge clk); check("err_set", wb_err, 1);
    tick(); set_exu(1'b1, 5'd0, 64'hAB, 1'b1);
    tick(); set_exu(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk); check("err_x0_rf_wen", rf_wen, 0); check("err_x0_sticky", wb_err, 1);
    tick();
    @(negedge clk); check("err_held", wb_err, 1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk); check("err_rst", wb_err, 0); check("err_rst_rf_wen", rf_wen, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
